// File: rtl/des_sbox_compress_if.sv
// Handshake and data bundle for the DES S-box compression stage.
//   in_valid/in_ready/data_in    : 48-bit expanded, key-mixed word from the key-mix stage
//   out_valid/out_ready/data_out : 32-bit f-function result towards the L/R swap logic
// Bit 1 is the MSB on both data buses (DES numbering).
interface des_sbox_compress_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:48] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:32] data_out;

  // Upstream/downstream environment view
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  // Compression block view
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/des_sbox_compress.sv
// DES round-function back end: 48->32 reduction through S1..S8, one S-box per
// clock on a shared lookup, optional P permutation, valid/ready output.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave view of des_sbox_compress_if (input word in, f result out)
//   busy  : high while substituting or holding a result
module des_sbox_compress #(
  parameter bit APPLY_P = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  des_sbox_compress_if.slave         bus,
  output logic                       busy
);

  localparam int unsigned IN_W  = 48;
  localparam int unsigned OUT_W = 32;

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  // One 256-bit row per S-box; entry (row*16+col) occupies nibble 63-index from the LSB
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // P permutation: output bit i takes the listed input bit
  function automatic logic [1:32] p_perm(input logic [1:32] x);
    return {x[16], x[7],  x[20], x[21], x[29], x[12], x[28], x[17],
            x[1],  x[15], x[23], x[26], x[5],  x[18], x[31], x[10],
            x[2],  x[8],  x[24], x[14], x[32], x[27], x[3],  x[9],
            x[19], x[13], x[30], x[6],  x[22], x[11], x[4],  x[25]};
  endfunction

  state_t          state, state_next;
  logic [1:IN_W]   sr, sr_next;
  logic [1:OUT_W]  acc, acc_next;
  logic [2:0]      cnt, cnt_next;
  logic [1:OUT_W]  data_out_next;
  logic            in_ready_next, out_valid_next, busy_next;

  logic [5:0]      six_c, idx_c, ridx_c;
  logic [255:0]    tab_c;
  logic [3:0]      sbox_c;

  // Combinational S-box lookup: row={b1,b6}, column={b2..b5}
  always_comb begin
    six_c  = sr[1:6];
    idx_c  = {six_c[5], six_c[0], six_c[4:1]};
    ridx_c = 6'd63 - idx_c;
    tab_c  = SBOX_TAB[cnt];
    sbox_c = tab_c[{ridx_c, 2'b00} +: 4];
  end

  // Next-state and datapath
  always_comb begin
    state_next    = state;
    sr_next       = sr;
    acc_next      = acc;
    cnt_next      = cnt;
    data_out_next = bus.data_out;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sr_next    = bus.data_in;
          acc_next   = '0;
          cnt_next   = 3'd0;
          state_next = SUB;
        end
      end
      SUB: begin
        sr_next  = {sr[7:IN_W], 6'b000000};
        acc_next = {acc[5:OUT_W], sbox_c};
        cnt_next = cnt + 3'd1;
        // Last S-box folds straight into the output register
        if (cnt == 3'd7) begin
          data_out_next = APPLY_P ? p_perm(acc_next) : acc_next;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == HOLD);
    busy_next      = (state_next != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sr            <= '0;
      acc           <= '0;
      cnt           <= 3'd0;
      bus.data_out  <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      sr            <= sr_next;
      acc           <= acc_next;
      cnt           <= cnt_next;
      bus.data_out  <= data_out_next;
      bus.in_ready  <= in_ready_next;
      bus.out_valid <= out_valid_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_des_sbox_compress.sv
// Directed bench for des_sbox_compress: one instance without P, one with P,
// both driven by the same stimulus.
module tb_des_sbox_compress;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:48] data_in;
  logic        out_ready;
  logic        busy_raw, busy_p;

  int checks;
  int errors;

  des_sbox_compress_if if_raw ();
  des_sbox_compress_if if_p ();

  assign if_raw.in_valid  = in_valid;
  assign if_raw.data_in   = data_in;
  assign if_raw.out_ready = out_ready;
  assign if_p.in_valid    = in_valid;
  assign if_p.data_in     = data_in;
  assign if_p.out_ready   = out_ready;

  des_sbox_compress #(.APPLY_P(1'b0)) u_raw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_raw),
    .busy  (busy_raw)
  );

  des_sbox_compress #(.APPLY_P(1'b1)) u_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_p),
    .busy  (busy_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one word while the block is idle; returns at the negedge after acceptance
  task automatic send(input logic [1:48] d);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count clock edges until out_valid, bounded at 20
  task automatic wait_out(output int lat);
    lat = 0;
    while (if_raw.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    data_in   = 48'hFFFF_FFFF_FFFF;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (if_raw.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", if_raw.in_ready); end
    checks++; if (if_raw.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", if_raw.out_valid); end
    checks++; if (if_raw.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want 00000000", if_raw.data_out); end
    checks++; if (busy_raw !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_raw); end
    checks++; if (if_p.data_out !== 32'h0 || if_p.out_valid !== 1'b0) begin errors++; $display("FAIL reset_p got %h/%b want 00000000/0", if_p.data_out, if_p.out_valid); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_zero();
    int lat;
    out_ready = 1'b1;
    send(48'h0);
    wait_out(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got %0d want 8", lat); end
    checks++; if (if_raw.data_out !== 32'hEFA72C4D) begin errors++; $display("FAIL zero_raw got %h want efa72c4d", if_raw.data_out); end
    checks++; if (if_p.data_out !== 32'hD8D8DBBC) begin errors++; $display("FAIL zero_p got %h want d8d8dbbc", if_p.data_out); end
    checks++; if (busy_raw !== 1'b1) begin errors++; $display("FAIL zero_busy_hold got %b want 1", busy_raw); end
    @(negedge clk);
    checks++; if (if_raw.out_valid !== 1'b0 || if_raw.in_ready !== 1'b1) begin errors++; $display("FAIL zero_drain got v=%b r=%b want v=0 r=1", if_raw.out_valid, if_raw.in_ready); end
  endtask

  task automatic test_patterns();
    logic [1:48] vin  [3];
    logic [1:32] vexp [3];
    int lat;
    vin[0] = 48'hFFFF_FFFF_FFFF; vexp[0] = 32'hD9CE3DCB;
    vin[1] = 48'h0410_4104_1041; vexp[1] = 32'h03DDEAD1;
    vin[2] = 48'h8208_2082_0820; vexp[2] = 32'h40DA4917;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(vin[i]);
      wait_out(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL pattern%0d_latency got %0d want 8", i, lat); end
      checks++; if (if_raw.data_out !== vexp[i]) begin errors++; $display("FAIL pattern%0d_raw got %h want %h", i, if_raw.data_out, vexp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(48'h0);
    wait_out(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d want 8", lat); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (if_raw.out_valid !== 1'b1 || if_raw.in_ready !== 1'b0 || if_raw.data_out !== 32'hEFA72C4D || if_p.data_out !== 32'hD8D8DBBC) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b raw=%h p=%h want v=1 r=0 raw=efa72c4d p=d8d8dbbc",
                 i, if_raw.out_valid, if_raw.in_ready, if_raw.data_out, if_p.data_out);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (if_raw.out_valid !== 1'b0 || if_raw.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", if_raw.out_valid, if_raw.in_ready); end
    checks++; if (busy_raw !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", busy_raw); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    out_ready = 1'b0;
    send(48'hFFFF_FFFF_FFFF);
    // Second word held by upstream during SUB
    in_valid = 1'b1;
    data_in  = 48'h0;
    wait_out(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL busy_first_latency got %0d want 8", lat); end
    checks++; if (if_raw.data_out !== 32'hD9CE3DCB) begin errors++; $display("FAIL busy_first_raw got %h want d9ce3dcb", if_raw.data_out); end
    checks++; if (if_raw.in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready_hold got %b want 0", if_raw.in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_raw.in_ready !== 1'b1 || if_raw.out_valid !== 1'b0) begin errors++; $display("FAIL busy_back_idle got r=%b v=%b want r=1 v=0", if_raw.in_ready, if_raw.out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL busy_second_latency got %0d want 8", lat); end
    checks++; if (if_raw.data_out !== 32'hEFA72C4D) begin errors++; $display("FAIL busy_second_raw got %h want efa72c4d", if_raw.data_out); end
    checks++; if (if_p.data_out !== 32'hD8D8DBBC) begin errors++; $display("FAIL busy_second_p got %h want d8d8dbbc", if_p.data_out); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    out_ready = 1'b1;
    send(48'hFFFF_FFFF_FFFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (if_raw.in_ready !== 1'b1 || if_raw.out_valid !== 1'b0 || busy_raw !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got r=%b v=%b b=%b want r=1 v=0 b=0", if_raw.in_ready, if_raw.out_valid, busy_raw); end
    checks++; if (if_raw.data_out !== 32'h0 || if_p.data_out !== 32'h0) begin errors++; $display("FAIL midrst_data got raw=%h p=%h want 00000000", if_raw.data_out, if_p.data_out); end
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_raw.out_valid !== 1'b0 || if_p.out_valid !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse got %0d pulses want 0", pulses); end
    send(48'h0);
    wait_out(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_latency got %0d want 8", lat); end
    checks++; if (if_p.data_out !== 32'hD8D8DBBC) begin errors++; $display("FAIL midrst_p got %h want d8d8dbbc", if_p.data_out); end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    test_reset();
    test_zero();
    test_patterns();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
